// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: default widths that
// match the core's PC and instruction widths, and the loader state encoding.
package im_loader_pkg;

  localparam int LOADER_ADDR_W = 4;
  localparam int LOADER_DATA_W = 8;

  typedef enum logic [2:0] {
    HDR     = 3'd0,
    PAYLOAD = 3'd1,
    CHK     = 3'd2,
    FILL    = 3'd3,
    RUN     = 3'd4,
    ERR     = 3'd5
  } loader_state_e;

endpackage

// File: rtl/im_loader.sv
// Instruction-memory loader: takes a framed byte stream (length, payload,
// XOR checksum), writes the payload from address 0, zero-fills the rest of
// the memory and only then releases the core through core_start.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W = LOADER_ADDR_W,
  parameter int DATA_W = LOADER_DATA_W,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              core_start,
  output logic              busy,
  output logic              error
);

  // One extra bit so a full-depth length never wraps back to zero.
  localparam int CNT_W = ADDR_W + 1;

  loader_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] len_q, len_d;
  logic [DATA_W-1:0] cksum_q, cksum_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [DATA_W-1:0] im_wdata_q, im_wdata_d;
  logic              core_start_q, core_start_d;

  logic accept;
  logic hdr_len_ok;
  logic last_payload;
  logic need_fill;
  logic fill_done;

  assign in_ready = rst_n & ~reload &
                    ((state_q == HDR) | (state_q == PAYLOAD) | (state_q == CHK));
  assign accept   = in_valid & in_ready;

  assign hdr_len_ok   = (int'(in_data) >= 1) && (int'(in_data) <= DEPTH);
  assign last_payload = (int'(cnt_q) == int'(len_q) - 1);
  assign need_fill    = (int'(len_q) < DEPTH);
  assign fill_done    = (int'(cnt_q) == DEPTH - 1);

  // Next-state, counter, checksum and write-port decisions for the frame FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    cksum_d      = cksum_q;
    im_we_d      = 1'b0;
    im_addr_d    = im_addr_q;
    im_wdata_d   = im_wdata_q;
    core_start_d = (state_q == RUN) && !reload;

    if (reload) begin
      state_d = HDR;
      cnt_d   = '0;
      cksum_d = '0;
    end else begin
      unique case (state_q)
        HDR: begin
          if (accept) begin
            len_d   = in_data;
            cksum_d = in_data;
            cnt_d   = '0;
            state_d = hdr_len_ok ? PAYLOAD : ERR;
          end
        end
        PAYLOAD: begin
          if (accept) begin
            im_we_d    = 1'b1;
            im_addr_d  = cnt_q[ADDR_W-1:0];
            im_wdata_d = in_data;
            cksum_d    = cksum_q ^ in_data;
            if (last_payload) begin
              state_d = CHK;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        CHK: begin
          if (accept) begin
            if (in_data != cksum_q) begin
              state_d = ERR;
            end else if (need_fill) begin
              state_d = FILL;
              cnt_d   = CNT_W'(len_q);
            end else begin
              state_d = RUN;
            end
          end
        end
        FILL: begin
          im_we_d    = 1'b1;
          im_addr_d  = cnt_q[ADDR_W-1:0];
          im_wdata_d = '0;
          cnt_d      = cnt_q + 1'b1;
          if (fill_done) begin
            state_d = RUN;
          end
        end
        RUN: begin
        end
        ERR: begin
        end
        default: begin
          state_d = HDR;
        end
      endcase
    end
  end

  // State and registered write port, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= HDR;
      cnt_q        <= '0;
      len_q        <= '0;
      cksum_q      <= '0;
      im_we_q      <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= '0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      cksum_q      <= cksum_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      core_start_q <= core_start_d;
    end
  end

  assign im_we      = im_we_q;
  assign im_addr    = im_addr_q;
  assign im_wdata   = im_wdata_q;
  assign core_start = core_start_q;
  assign busy       = (state_q == PAYLOAD) || (state_q == CHK) || (state_q == FILL);
  assign error      = (state_q == ERR);

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader. The reference model keeps the bytes
// accepted since the last reload and derives from them a per-cycle schedule
// of memory writes, the cycle core_start must rise and the cycle error must
// rise; a single compare process checks the DUT against it every cycle.
module tb_im_loader;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int INF    = 1 << 30;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              reload;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_wdata;
  logic              core_start;
  logic              busy;
  logic              error;

  int errors = 0;
  int checks = 0;

  im_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .reload     (reload),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .core_start (core_start),
    .busy       (busy),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  // Reference model state.
  logic [7:0] got[$];
  int sched_addr[int];
  int sched_data[int];
  int start_cycle = INF;
  int err_cycle   = INF;
  bit done_ok     = 1'b0;
  int cyc         = 0;
  int wlog[$];

  function automatic bit m_len_ok();
    if (got.size() == 0) return 1'b0;
    return (int'(got[0]) >= 1) && (int'(got[0]) <= DEPTH);
  endfunction

  function automatic bit m_accepting();
    if (got.size() == 0) return 1'b1;
    return m_len_ok() && (got.size() < int'(got[0]) + 2);
  endfunction

  function automatic bit m_busy();
    if (!m_len_ok()) return 1'b0;
    return (got.size() < int'(got[0]) + 2) || (done_ok && (cyc <= start_cycle - 2));
  endfunction

  function automatic void m_accept(input logic [7:0] b);
    int k;
    int len;
    logic [7:0] x;
    got.push_back(b);
    k = got.size();
    len = int'(got[0]);
    if (k == 1) begin
      if (!m_len_ok()) err_cycle = cyc + 1;
    end else if (k <= len + 1) begin
      sched_addr[cyc + 1] = k - 2;
      sched_data[cyc + 1] = int'(b);
    end else begin
      x = 8'h00;
      foreach (got[i]) x ^= got[i];
      if (x == 8'h00) begin
        for (int j = 0; j < DEPTH - len; j++) begin
          sched_addr[cyc + 2 + j] = len + j;
          sched_data[cyc + 2 + j] = 0;
        end
        start_cycle = cyc + 2 + DEPTH - len;
        done_ok = 1'b1;
      end else begin
        err_cycle = cyc + 1;
      end
    end
  endfunction

  function automatic void m_abort();
    int keys[$];
    got.delete();
    foreach (sched_addr[k]) if (k > cyc) keys.push_back(k);
    foreach (keys[i]) begin
      sched_addr.delete(keys[i]);
      sched_data.delete(keys[i]);
    end
    start_cycle = INF;
    err_cycle = INF;
    done_ok = 1'b0;
  endfunction

  // Compare every output against the model, then advance the model with this cycle's inputs.
  always @(negedge clk) begin : model_compare
    bit exp_ready;
    bit exp_we;
    exp_ready = rst_n && !reload && m_accepting();
    check_output("in_ready", int'(in_ready), int'(exp_ready));
    if (rst_n) begin
      exp_we = sched_addr.exists(cyc) ? 1'b1 : 1'b0;
      check_output("im_we", int'(im_we), int'(exp_we));
      if (im_we && exp_we) begin
        check_output("im_addr", int'(im_addr), sched_addr[cyc]);
        check_output("im_wdata", int'(im_wdata), sched_data[cyc]);
      end
      check_output("core_start", int'(core_start), (cyc >= start_cycle) ? 1 : 0);
      check_output("error", int'(error), (cyc >= err_cycle) ? 1 : 0);
      check_output("busy", int'(busy), int'(m_busy()));
      if (im_we) wlog.push_back(int'(im_addr) * 256 + int'(im_wdata));
    end
    if (sched_addr.exists(cyc)) begin
      sched_addr.delete(cyc);
      sched_data.delete(cyc);
    end
    if (!rst_n || reload) m_abort();
    else if (in_valid && exp_ready) m_accept(in_data);
    cyc++;
  end

  // Stimulus helpers; all of them start and end just after a rising edge.
  logic [7:0] frame[$];

  task automatic reset_dut();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    reload = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int min_gap, input int max_gap);
    int gap;
    bit ok;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, min_gap)) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data = b;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_output("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input int min_gap, input int max_gap);
    foreach (frame[i]) send_byte(frame[i], (i == 0) ? 0 : min_gap, (i == 0) ? 0 : max_gap);
  endtask

  task automatic reload_pulse();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  task automatic wait_settle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (core_start || error) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_output("settle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic basic_frame();
    frame = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
  endtask

  task automatic check_basic_log(input string tag);
    int exp_data[3] = '{8'h11, 8'h22, 8'h33};
    int want;
    check_output({tag, "_writes"}, wlog.size(), 16);
    for (int i = 0; i < 16; i++) begin
      want = i * 256 + ((i < 3) ? exp_data[i] : 0);
      if (i < wlog.size()) check_output({tag, "_write"}, wlog[i], want);
    end
    @(negedge clk);
    check_output({tag, "_core_start"}, int'(core_start), 1);
    check_output({tag, "_busy"}, int'(busy), 0);
    check_output({tag, "_error"}, int'(error), 0);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin : main
    int len;
    int mode;
    int cut;
    logic [7:0] x;
    logic [7:0] b;

    reset_dut();

    @(negedge clk);
    check_output("rst_core_start", int'(core_start), 0);
    check_output("rst_error", int'(error), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_in_ready", int'(in_ready), 1);
    check_output("rst_im_we", int'(im_we), 0);
    check_output("rst_im_addr", int'(im_addr), 0);
    @(posedge clk); #1;

    $display("[TB] basic load");
    wlog.delete();
    basic_frame();
    apply_stimulus(0, 0);
    wait_settle();
    check_basic_log("basic");

    $display("[TB] reload while running");
    reload_pulse();
    @(negedge clk);
    check_output("run_reload_core_start", int'(core_start), 0);
    check_output("run_reload_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    wlog.delete();
    basic_frame();
    apply_stimulus(0, 0);
    wait_settle();
    check_basic_log("reloaded");

    $display("[TB] full image");
    reload_pulse();
    wlog.delete();
    frame = '{8'h10};
    for (int i = 0; i < 16; i++) frame.push_back(8'(i));
    frame.push_back(8'h10);
    apply_stimulus(0, 0);
    @(negedge clk);
    check_output("full_start_early", int'(core_start), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("full_start", int'(core_start), 1);
    check_output("full_writes", wlog.size(), 16);
    if (wlog.size() == 16) check_output("full_last_write", wlog[15], 15 * 256 + 15);
    @(posedge clk); #1;

    $display("[TB] bad checksum");
    reload_pulse();
    frame = '{8'h02, 8'hAA, 8'h55, 8'h00};
    apply_stimulus(0, 0);
    @(negedge clk);
    check_output("badchk_error", int'(error), 1);
    check_output("badchk_core_start", int'(core_start), 0);
    check_output("badchk_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = 8'h5A;
    repeat (2) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reload_pulse();
    @(negedge clk);
    check_output("badchk_reload_error", int'(error), 0);
    check_output("badchk_reload_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    $display("[TB] bad length");
    wlog.delete();
    frame = '{8'h00};
    apply_stimulus(0, 0);
    @(negedge clk);
    check_output("len0_error", int'(error), 1);
    check_output("len0_core_start", int'(core_start), 0);
    @(posedge clk); #1;
    reload_pulse();
    frame = '{8'h11};
    apply_stimulus(0, 0);
    @(negedge clk);
    check_output("len17_error", int'(error), 1);
    check_output("len17_busy", int'(busy), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("badlen_writes", wlog.size(), 0);
    @(posedge clk); #1;

    $display("[TB] backpressure");
    reload_pulse();
    wlog.delete();
    basic_frame();
    apply_stimulus(1, 3);
    wait_settle();
    check_basic_log("bp");

    $display("[TB] reload mid payload");
    reload_pulse();
    wlog.delete();
    frame = '{8'h05, 8'h01, 8'h02};
    apply_stimulus(0, 0);
    in_valid = 1'b1;
    in_data = 8'h03;
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_output("abort_in_ready", int'(in_ready), 1);
    check_output("abort_busy", int'(busy), 0);
    check_output("abort_writes", wlog.size(), 2);
    @(posedge clk); #1;
    wlog.delete();
    basic_frame();
    apply_stimulus(0, 0);
    wait_settle();
    check_basic_log("after_abort");

    $display("[TB] random frames");
    for (int f = 0; f < 30; f++) begin
      reload_pulse();
      mode = int'($urandom_range(9, 0));
      if (mode == 0) begin
        len = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(255, 17));
        frame = '{8'(len)};
        apply_stimulus(0, 0);
        wait_settle();
      end else begin
        len = int'($urandom_range(16, 1));
        frame = '{8'(len)};
        x = 8'(len);
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom_range(255, 0));
          frame.push_back(b);
          x ^= b;
        end
        if (mode == 1) x ^= 8'($urandom_range(255, 1));
        frame.push_back(x);
        if (mode == 2) begin
          cut = int'($urandom_range(len, 1));
          for (int i = 0; i < cut; i++) send_byte(frame[i], 0, 2);
          in_valid = 1'b1;
          in_data = frame[cut];
          reload = 1'b1;
          @(posedge clk); #1;
          reload = 1'b0;
          in_valid = 1'b0;
        end else begin
          apply_stimulus(0, 2);
          wait_settle();
        end
      end
      in_valid = 1'b1;
      in_data = 8'($urandom_range(255, 0));
      repeat (2) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
    end

    repeat (3) begin
      @(posedge clk); #1;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Writer side of the instruction-memory port. The core only reads that memory; this block fills it.
- Accepts a framed byte stream over a valid/ready handshake: a length byte, up to DEPTH payload bytes, then an XOR checksum byte.
- Writes the payload to addresses 0.., then zero-fills the remaining addresses.
- Holds the core's start low until a verified image is loaded, then raises it.

Parameters:
ADDR_W, 4, instruction memory address width (matches core PC width)
DATA_W, 8, instruction width
DEPTH, 1<<ADDR_W, number of instruction words

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_data  input  DATA_W  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts in_data this cycle
reload  input  1  single-cycle request to drop the core and start a new load
im_we  output  1  instruction memory write enable
im_addr  output  ADDR_W  instruction memory write address
im_wdata  output  DATA_W  instruction memory write data
core_start  output  1  start level to the core; 1 only while a verified image is present
busy  output  1  state is PAYLOAD, CHK or FILL
error  output  1  frame rejected; sticky until reload or reset

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Reset values: state HDR, cnt 0, len 0, cksum 0, im_we 0, im_addr 0, im_wdata 0, core_start 0, error 0.
- in_ready is forced 0 while rst_n=0.
- Accept occurs on in_valid & in_ready.
- in_ready is combinational: 1 in HDR, PAYLOAD, CHK when reload=0; 0 otherwise.
- Write port is registered: a payload byte accepted in cycle t gives im_we=1, im_addr=cnt, im_wdata=byte in cycle t+1.
- im_we is 0 in every cycle with no write.

States:
- HDR: on accept, len := in_data and cksum := in_data.
  - If 1 <= in_data <= DEPTH, go to PAYLOAD with cnt := 0.
  - Otherwise go to ERR.
- PAYLOAD: on accept, write byte at cnt and cksum ^= byte.
  - When cnt == len-1, go to CHK; else cnt++.
- CHK: on accept, compare in_data with cksum.
  - Mismatch: go to ERR.
  - Match with len < DEPTH: go to FILL with cnt := len.
  - Match with len == DEPTH: go to RUN.
- FILL: no accept. Writes 0 at cnt, one address per cycle, cnt++.
  - After writing address DEPTH-1, go to RUN.
  - Exactly DEPTH-len write cycles.
- RUN: core_start=1, registered, so it is high the cycle after entering RUN. No accept.
- ERR: error=1, core_start=0, no accept.

Boundary rules:
- Gaps in in_valid during HDR, PAYLOAD or CHK stall the FSM; no state change.
- cnt is ADDR_W+1 bits wide, so len == DEPTH does not alias to 0.
- reload=1 in any state moves to HDR next cycle and clears error, cnt, cksum.
  - core_start drops to 0 the next cycle.
  - Any im_we pending from the previous cycle's accept still completes.
- reload and in_valid in the same cycle: reload wins and the byte is not accepted (in_ready=0).
- rst_n=0 overrides reload and any in-flight frame.
- Memory contents after ERR or an aborted frame are undefined. core_start stays 0, so the core never fetches them.
- Memory writes from a failed frame are not rolled back.

Decomposition:
- Shared package im_loader_pkg holds:
  - ADDR_W and DATA_W defaults, consistent with core PC and instruction widths.
  - Loader state encoding: HDR=0, PAYLOAD=1, CHK=2, FILL=3, RUN=4, ERR=5, 3 bits.
- No sub-module. FSM, counter, checksum register and write-port register live in one module.
- Top-level integration muxes im_we/im_addr/im_wdata into the memory write port. The core's read port is unchanged.

Test Plan:
- Basic load:
  - Stimulus: reset, then bytes 0x03, 0x11, 0x22, 0x33, 0x03 back-to-back.
  - Response: writes (0,0x11), (1,0x22), (2,0x33), then 13 zero writes to addresses 3..15.
  - Then core_start=1; busy=0; error=0.
- Full image:
  - Stimulus: length 0x10, 16 bytes 0x00..0x0F, checksum 0x10.
  - Response: 16 writes, no FILL cycles, core_start=1 two cycles after the checksum accept.
- Bad checksum:
  - Stimulus: 0x02, 0xAA, 0x55, then 0x00 (expected 0xFD).
  - Response: error=1, core_start=0, in_ready=0.
  - Then reload pulse: error=0, in_ready=1 the next cycle.
- Bad length:
  - Stimulus: header 0x00, and separately header 0x11.
  - Response: ERR immediately, no im_we, core_start=0.
- Backpressure:
  - Stimulus: basic-load frame with in_valid low for 1-3 random cycles between bytes.
  - Response: identical write sequence and final state to the basic load.
- Reload during operation:
  - Stimulus: reload mid-PAYLOAD after 2 of 5 bytes, with in_valid=1 the same cycle. Separately, reload while in RUN.
  - Response: the byte in the reload cycle is not accepted; HDR next cycle.
  - From RUN, core_start falls to 0 one cycle after reload; a following valid frame completes normally.
